mem_bank_controller: RTL
========================

// Module: mem_bank_controller
// PURPOSE
//  Memory-controller end of the compute<->memory interface. Accepts read and write requests
//  (en/addr/data_width/format) from a compute block and services them on one single-port
//  bank (en/addr/data, 1-cycle read latency). Splits double-width accesses into two bank
//  accesses, converts fixed-point format on single-width data, arbitrates rd/wr on the port.
// PARAMETERS
//  DATA_W      16  bank word width (bits, signed fixed-point)
//  ADDR_W      15  bank address width
//  FRAC_W      4   width of the format (fractional-bit count) fields
//  STORE_FRAC  10  fractional bits of values as stored in the bank
// PORTS
//  clk           in   1         clock
//  rst           in   1         synchronous reset, active-high
//  rd_en         in   1         read request
//  rd_addr       in   ADDR_W    read address (low word for double width)
//  rd_width      in   1         0=single, 1=double
//  rd_frac       in   FRAC_W    fractional bits the requester wants
//  rd_ready      out  1         read request accepted this cycle if rd_en
//  rd_data       out  2*DATA_W  read result
//  rd_valid      out  1         rd_data valid, 1-cycle pulse
//  wr_en         in   1         write request
//  wr_chip_en    in   1         write qualifier; wr_en without it is a no-op
//  wr_addr       in   ADDR_W    write address (low word for double width)
//  wr_width      in   1         0=single, 1=double
//  wr_frac       in   FRAC_W    fractional bits of wr_data
//  wr_data       in   2*DATA_W  write data (single uses [DATA_W-1:0])
//  wr_ready      out  1         write request accepted this cycle if wr_en&wr_chip_en
//  bank_rd_en    out  1         bank read strobe
//  bank_rd_addr  out  ADDR_W    bank read address
//  bank_rd_data  in   DATA_W    bank read data, valid 1 cycle after bank_rd_en
//  bank_wr_en    out  1         bank write strobe
//  bank_chip_en  out  1         bank chip enable (= bank_wr_en)
//  bank_wr_addr  out  ADDR_W    bank write address
//  bank_wr_data  out  DATA_W    bank write data
// BEHAVIOUR
//  - FSM IDLE / SECOND. wr_ready = (IDLE); rd_ready = (IDLE & ~(wr_en&wr_chip_en)).
//  - IDLE accept: bank access for the low word driven combinationally in the accept cycle T.
//    Single -> stay IDLE (1 op/cycle). Double -> SECOND; high word at addr+1 (mod 2^ADDR_W,
//    0x7FFF wraps to 0) in T+1 from registered request; then IDLE.
//  - Simultaneous rd_en and wr_en&wr_chip_en in IDLE: write wins; read not accepted, requester
//    holds rd_en. Never both bank_rd_en and bank_wr_en in one cycle.
//  - Read latency: single -> rd_valid at T+1; double -> low word latched T+1, rd_valid at T+2
//    with rd_data = {hi, lo}. Requests arriving in SECOND are ignored (ready low).
//  - Format cast, single width only; double width is raw, no cast.
//    Write: shift = STORE_FRAC - wr_frac; left shift saturates to [0x8000,0x7FFF];
//    right shift is arithmetic (floor). Read: shift = rd_frac - STORE_FRAC, same rules.
//    Single rd_data: cast value in [DATA_W-1:0], sign-extended to 2*DATA_W.
//  - Reset: state=IDLE, rd_valid=0, rd_data=0, pending double and latched low word discarded.
//    While rst=1, all bank_* enables are 0 and both ready outputs are 0.
// TESTING
//  1 wr single 0x0400 frac10 @5 -> bank_wr 0x0400 @5 at T; rd @5 frac8 -> rd_data 0x0100, rd_valid T+1
//  2 wr single 0x7000 frac8 -> bank 0x7FFF (sat); 0x9000 frac8 -> 0x8000; rd 0xFFFF frac8 -> 0xFFFF (floor)
//  3 wr double 0x12345678 @0x7FFF -> 0x5678@0x7FFF at T, 0x1234@0x0000 at T+1, wr_ready=0 at T+1;
//    rd double @0x7FFF -> rd_valid at T+2, rd_data=0x12345678
//  4 rd_en+wr_en same cycle -> bank write only, rd_ready=0; read accepted next cycle, rd_valid one later
//  5 rst=1 during SECOND of double read -> no rd_valid, no bank access, IDLE and ready after rst drops
//  6 wr_en=1, wr_chip_en=0, rd_en=1 -> no bank write; read accepted that cycle

Source files
------------

// File: rtl/mem_bank_controller.sv
// Memory-side controller: serves compute read/write requests on one single-port bank.
// Latency: single read data returns 1 cycle after accept, double read returns 2 cycles after accept.
// Backpressure: ready drops for the second word of a double, and rd_ready also drops while a write is accepted.
module mem_bank_controller #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 15,
  parameter int FRAC_W     = 4,
  parameter int STORE_FRAC = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_width,
  input  logic [FRAC_W-1:0]   rd_frac,
  output logic                rd_ready,
  output logic [2*DATA_W-1:0] rd_data,
  output logic                rd_valid,
  input  logic                wr_en,
  input  logic                wr_chip_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                wr_width,
  input  logic [FRAC_W-1:0]   wr_frac,
  input  logic [2*DATA_W-1:0] wr_data,
  output logic                wr_ready,
  output logic                bank_rd_en,
  output logic [ADDR_W-1:0]   bank_rd_addr,
  input  logic [DATA_W-1:0]   bank_rd_data,
  output logic                bank_wr_en,
  output logic                bank_chip_en,
  output logic [ADDR_W-1:0]   bank_wr_addr,
  output logic [DATA_W-1:0]   bank_wr_data
);

  // Headroom for a left shift by the largest magnitude the signed shift field can hold.
  localparam int WIDE_W = DATA_W + 2**(FRAC_W+1);
  localparam logic signed [FRAC_W+1:0] SF = (FRAC_W+2)'(STORE_FRAC);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t              state;
  logic                op_wr;
  logic [ADDR_W-1:0]   sec_addr;
  logic [DATA_W-1:0]   sec_wdata;
  logic [DATA_W-1:0]   lo_q;
  logic                rd_dbl_q;
  logic [FRAC_W-1:0]   rd_frac_q;
  logic                wr_req;
  logic signed [FRAC_W+1:0] sh_w;
  logic signed [FRAC_W+1:0] sh_r;
  logic [DATA_W-1:0]   rd_cast;

  // Positive shift moves left and saturates, negative shift is an arithmetic (flooring) right shift.
  function automatic logic [DATA_W-1:0] fx_cast(input logic [DATA_W-1:0] v,
                                                input logic signed [FRAC_W+1:0] sh);
    logic signed [WIDE_W-1:0] wide;
    logic [FRAC_W:0]          mag;
    logic [DATA_W-1:0]        res;
    wide = WIDE_W'($signed(v));
    mag  = (FRAC_W+1)'(sh[FRAC_W+1] ? -sh : sh);
    if (sh[FRAC_W+1]) wide = wide >>> mag;
    else              wide = wide <<< mag;
    if (wide[WIDE_W-1:DATA_W-1] != {(WIDE_W-DATA_W+1){wide[WIDE_W-1]}})
      res = wide[WIDE_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      res = wide[DATA_W-1:0];
    return res;
  endfunction

  assign wr_req  = wr_en & wr_chip_en;
  assign sh_w    = SF - $signed({2'b00, wr_frac});
  assign sh_r    = $signed({2'b00, rd_frac_q}) - SF;
  assign rd_cast = fx_cast(bank_rd_data, sh_r);

  assign wr_ready     = ~rst & (state == IDLE);
  assign rd_ready     = ~rst & (state == IDLE) & ~wr_req;
  assign bank_chip_en = bank_wr_en;

  // Bank port: low word straight from the request in IDLE, high word from the saved request in SECOND.
  always_comb begin
    bank_rd_en   = 1'b0;
    bank_rd_addr = '0;
    bank_wr_en   = 1'b0;
    bank_wr_addr = '0;
    bank_wr_data = '0;
    if (!rst) begin
      if (state == IDLE) begin
        if (wr_req) begin
          bank_wr_en   = 1'b1;
          bank_wr_addr = wr_addr;
          bank_wr_data = wr_width ? wr_data[DATA_W-1:0] : fx_cast(wr_data[DATA_W-1:0], sh_w);
        end else if (rd_en) begin
          bank_rd_en   = 1'b1;
          bank_rd_addr = rd_addr;
        end
      end else if (op_wr) begin
        bank_wr_en   = 1'b1;
        bank_wr_addr = sec_addr;
        bank_wr_data = sec_wdata;
      end else begin
        bank_rd_en   = 1'b1;
        bank_rd_addr = sec_addr;
      end
    end
  end

  // Read result is formed as the bank data arrives; zero whenever no result is presented.
  always_comb begin
    rd_data = '0;
    if (rd_valid) begin
      if (rd_dbl_q) rd_data = {bank_rd_data, lo_q};
      else          rd_data = {{DATA_W{rd_cast[DATA_W-1]}}, rd_cast};
    end
  end

  // Request FSM: accepts in IDLE, issues the high word of a double in SECOND, tracks read returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      sec_addr  <= '0;
      sec_wdata <= '0;
      lo_q      <= '0;
      rd_dbl_q  <= 1'b0;
      rd_frac_q <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            if (wr_width) begin
              state     <= SECOND;
              op_wr     <= 1'b1;
              sec_addr  <= wr_addr + ADDR_W'(1);
              sec_wdata <= wr_data[2*DATA_W-1:DATA_W];
            end
          end else if (rd_en) begin
            rd_frac_q <= rd_frac;
            if (rd_width) begin
              state    <= SECOND;
              op_wr    <= 1'b0;
              sec_addr <= rd_addr + ADDR_W'(1);
            end else begin
              rd_valid <= 1'b1;
              rd_dbl_q <= 1'b0;
            end
          end
        end
        SECOND: begin
          state <= IDLE;
          if (!op_wr) begin
            lo_q     <= bank_rd_data;
            rd_valid <= 1'b1;
            rd_dbl_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
